mem_port_arbiter: RTL and testbench

- Sequences one shared single-ported 16-bit memory between two requesters: instruction fetch (read-only) and the data-memory stage (read/write).
- Sits between the fetch/memory pipeline stages and one memory instance.
- Counts a fixed multi-cycle access latency and returns registered read data with a one-cycle done pulse.
- Produces per-requester stall signals for the pipeline.

---
 rtl/mem_port_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported 16-bit memory between instruction fetch
//   (read-only) and the data-memory stage (read/write). Each access holds
//   the port for MEM_LAT cycles. Read data is registered, and the matching
//   done output pulses for one cycle. Data has fixed priority. A requester
//   whose done is high has its request masked for that cycle, so the two
//   requesters alternate when both request continuously.
//
// Parameters
//   MEM_LAT   cycles the memory port is held per access (1..8)
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   halt                      blocks new fetch grants only
//   f_req, f_addr             fetch request / address
//   f_done, f_rdata, f_stall  fetch completion pulse, instruction, stall
//   d_req, d_wr, d_addr,
//   d_wdata                   data request, write flag, address, write data
//   d_done, d_rdata, d_stall  data completion pulse, read data, stall
//   mem_en, mem_wr, mem_addr,
//   mem_wdata, mem_rdata      memory port (mem_rdata is combinational)
//   busy                      arbiter is in an access
//   err                       misaligned-request pulse (optional feature)
//
// Optional feature (macro ARB_ALIGN_CHK_EN)
//   When the macro is defined, a granted request with addr[0]=1 does not
//   access memory. It produces err plus its done pulse on the next cycle
//   and leaves rdata and the latched values untouched. When the macro is
//   undefined, the address passes through unchanged and err is tied to 0.
module mem_port_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic        f_done,
  output logic [15:0] f_rdata,
  output logic        f_stall,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_done,
  output logic [15:0] d_rdata,
  output logic        d_stall,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

  state_t      state, next_state;
  logic [2:0]  cnt;
  logic [15:0] lat_addr;
  logic [15:0] lat_wdata;
  logic        lat_wr;

  logic f_elig, d_elig;
  logic f_bad, d_bad;
  logic d_start, f_start;
  logic last;

  // A requester whose done is high this cycle is masked for the cycle.
  // This gives the bubble and stops a stale address being re-issued.
  assign f_elig = f_req & ~f_done & ~halt;
  assign d_elig = d_req & ~d_done;

`ifdef ARB_ALIGN_CHK_EN
  assign f_bad = f_addr[0];
  assign d_bad = d_addr[0];
`else
  assign f_bad = 1'b0;
  assign d_bad = 1'b0;
`endif

  // Fetch is only considered when data is not eligible (fixed priority).
  assign d_start = d_elig & ~d_bad;
  assign f_start = ~d_elig & f_elig & ~f_bad;
  assign last    = (cnt == 3'd0);

  assign f_stall = f_req & ~f_done;
  assign d_stall = d_req & ~d_done;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (d_start)      next_state = DATA;
        else if (f_start) next_state = FETCH;
      end
      FETCH, DATA: begin
        if (last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output logic: the address and write data always come from the latches,
  // so the memory bus does not toggle while the arbiter is idle.
  always_comb begin
    mem_en    = (state != IDLE);
    mem_wr    = (state == DATA) & lat_wr;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    busy      = (state != IDLE);
  end

  // Datapath: latches, latency counter, done pulses and read-data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 3'd0;
      lat_addr  <= 16'h0000;
      lat_wdata <= 16'h0000;
      lat_wr    <= 1'b0;
      f_done    <= 1'b0;
      d_done    <= 1'b0;
      f_rdata   <= 16'h0000;
      d_rdata   <= 16'h0000;
`ifdef ARB_ALIGN_CHK_EN
      err       <= 1'b0;
`endif
    end else begin
      f_done <= 1'b0;
      d_done <= 1'b0;
`ifdef ARB_ALIGN_CHK_EN
      err    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (d_elig) begin
            if (d_bad) begin
              // A misaligned grant completes at once, with no memory access.
              d_done <= 1'b1;
`ifdef ARB_ALIGN_CHK_EN
              err    <= 1'b1;
`endif
            end else begin
              lat_addr  <= d_addr;
              lat_wdata <= d_wdata;
              lat_wr    <= d_wr;
              cnt       <= LAT_INIT;
            end
          end else if (f_elig) begin
            if (f_bad) begin
              f_done <= 1'b1;
`ifdef ARB_ALIGN_CHK_EN
              err    <= 1'b1;
`endif
            end else begin
              lat_addr <= f_addr;
              lat_wr   <= 1'b0;
              cnt      <= LAT_INIT;
            end
          end
        end
        FETCH: begin
          if (last) begin
            f_done  <= 1'b1;
            f_rdata <= mem_rdata;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DATA: begin
          if (last) begin
            d_done <= 1'b1;
            if (!lat_wr) d_rdata <= mem_rdata;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: cnt <= 3'd0;
      endcase
    end
  end

`ifndef ARB_ALIGN_CHK_EN
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter, built with MEM_LAT=3. A request
//   applied in cycle 0 is granted at the following edge and occupies the
//   port in cycles 1-3. Its done pulse appears in cycle 4. A small behavioural
//   memory answers mem_addr combinationally. It is filled with
//   addr ^ 16'hC3C3, except for 0x010 = 0xABCD and 0x011 = 0x1234.
module tb_mem_port_arbiter;

  localparam int LAT = 3;

  logic        clk;
  logic        rst;
  logic        halt;
  logic        f_req;
  logic [15:0] f_addr;
  logic        f_done;
  logic [15:0] f_rdata;
  logic        f_stall;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_done;
  logic [15:0] d_rdata;
  logic        d_stall;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;
  logic        err;

  logic        mem_init;
  logic [15:0] mem [0:1023];

  int checks;
  int passes;

  mem_port_arbiter #(.MEM_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .halt      (halt),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_done    (f_done),
    .f_rdata   (f_rdata),
    .f_stall   (f_stall),
    .d_req     (d_req),
    .d_wr      (d_wr),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .d_stall   (d_stall),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .err       (err)
  );

  // Clock: 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: combinational read and registered write.
  // The memory is filled while mem_init is high.
  assign mem_rdata = mem[mem_addr[9:0]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++)
        mem[i] <= (i == 16) ? 16'hABCD : (i == 17) ? 16'h1234 : (16'(i) ^ 16'hC3C3);
    end else if (mem_en && mem_wr) begin
      mem[mem_addr[9:0]] <= mem_wdata;
    end
  end

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Drives every requester input, then lets combinational outputs settle
  task automatic applyStimulus(input logic h, input logic fr, input logic [15:0] fa,
                               input logic dr, input logic dw, input logic [15:0] da,
                               input logic [15:0] dwd);
    halt    = h;
    f_req   = fr;
    f_addr  = fa;
    d_req   = dr;
    d_wr    = dw;
    d_addr  = da;
    d_wdata = dwd;
    #1;
  endtask

  // Advances to 2 time units after the next rising edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Steps until the selected done output rises, with a bounded wait.
  // cycles counts the steps taken. wr_cycles counts the cycles in which
  // the write appeared on the port with the given address and data.
  task automatic waitDone(input string tag, input bit is_data,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          output int cycles, output int wr_cycles);
    logic seen;
    seen      = 1'b0;
    cycles    = 0;
    wr_cycles = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      cycles++;
      if (mem_wr && mem_addr == addr && mem_wdata == wdata) wr_cycles++;
      seen = is_data ? d_done : f_done;
    end
    checkOutput(tag, 16'(seen), 16'd1);
  endtask

  // Runs one isolated data access, then leaves one idle bubble cycle
  task automatic dataAccess(input string tag, input logic wr, input logic [15:0] addr,
                            input logic [15:0] wdata, output int cycles, output int wr_cycles,
                            output logic [15:0] rdata_at_done);
    applyStimulus(1'b0, 1'b0, 16'h0010, 1'b1, wr, addr, wdata);
    waitDone(tag, 1'b1, addr, wdata, cycles, wr_cycles);
    rdata_at_done = d_rdata;
    applyStimulus(1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
  endtask

  // Main directed sequence
  initial begin
    int          cyc, wrc;
    logic [15:0] rd;
    logic [15:0] ev[$];
    logic        any_done;

    checks   = 0;
    passes   = 0;
    rst      = 1'b1;
    mem_init = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #2;
    mem_init = 1'b0;
    rst      = 1'b0;
    #1;

    // Reset state
    checkOutput("rst_f_done", 16'(f_done), 16'd0);
    checkOutput("rst_d_done", 16'(d_done), 16'd0);
    checkOutput("rst_err", 16'(err), 16'd0);
    checkOutput("rst_f_rdata", f_rdata, 16'h0000);
    checkOutput("rst_d_rdata", d_rdata, 16'h0000);
    checkOutput("rst_busy", 16'(busy), 16'd0);
    checkOutput("rst_mem_en", 16'(mem_en), 16'd0);

    // Single fetch from 0x0010. The port is used in cycles 1-3, and done
    // pulses in cycle 4.
    applyStimulus(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("fetch_stall_c0", 16'(f_stall), 16'd1);
    step();
    checkOutput("fetch_busy_c1", 16'(busy), 16'd1);
    checkOutput("fetch_mem_en_c1", 16'(mem_en), 16'd1);
    checkOutput("fetch_mem_addr_c1", mem_addr, 16'h0010);
    checkOutput("fetch_mem_wr_c1", 16'(mem_wr), 16'd0);
    checkOutput("fetch_stall_c1", 16'(f_stall), 16'd1);
    step();
    step();
    checkOutput("fetch_done_c3", 16'(f_done), 16'd0);
    step();
    checkOutput("fetch_done_c4", 16'(f_done), 16'd1);
    checkOutput("fetch_rdata_c4", f_rdata, 16'hABCD);
    checkOutput("fetch_stall_c4", 16'(f_stall), 16'd0);
    checkOutput("fetch_busy_c4", 16'(busy), 16'd0);
    applyStimulus(1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
    checkOutput("fetch_done_c5", 16'(f_done), 16'd0);
    checkOutput("fetch_rdata_hold", f_rdata, 16'hABCD);

    // Data read, write, then read back. A write leaves d_rdata unchanged.
    dataAccess("rd100_done", 1'b0, 16'h0100, 16'h0000, cyc, wrc, rd);
    checkOutput("rd100_latency", 16'(cyc), 16'(LAT + 1));
    checkOutput("rd100_rdata", rd, 16'hC2C3);
    dataAccess("wr200_done", 1'b1, 16'h0200, 16'h5A5A, cyc, wrc, rd);
    checkOutput("wr200_latency", 16'(cyc), 16'(LAT + 1));
    checkOutput("wr200_port_cycles", 16'(wrc), 16'(LAT));
    checkOutput("wr200_rdata_kept", rd, 16'hC2C3);
    dataAccess("rd200_done", 1'b0, 16'h0200, 16'h0000, cyc, wrc, rd);
    checkOutput("rd200_rdata", rd, 16'h5A5A);

    // Both requesters held high. Expected order: data done in cycle 4,
    // fetch in 8, data in 12, fetch in 16. Each done falls in an idle
    // bubble cycle.
    applyStimulus(1'b0, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0100, 16'h0000);
    for (int c = 1; c <= 18; c++) begin
      step();
      if (d_done) begin
        ev.push_back({c[11:0], 4'hD});
        checkOutput("alt_d_rdata", d_rdata, 16'hC2C3);
      end
      if (f_done) begin
        ev.push_back({c[11:0], 4'hF});
        checkOutput("alt_f_rdata", f_rdata, 16'hABCD);
      end
      if (d_done || f_done) checkOutput("alt_gap_idle", 16'(busy), 16'd0);
    end
    applyStimulus(1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (4) step();
    checkOutput("alt_count", 16'(ev.size()), 16'd4);
    while (ev.size() < 4) ev.push_back(16'hFFFF);
    checkOutput("alt_ev0", ev[0], 16'h004D);
    checkOutput("alt_ev1", ev[1], 16'h008F);
    checkOutput("alt_ev2", ev[2], 16'h00CD);
    checkOutput("alt_ev3", ev[3], 16'h010F);

    // halt blocks the fetch grant but not a data access
    applyStimulus(1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000);
    any_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      any_done = any_done | busy;
    end
    checkOutput("halt_no_grant", 16'(any_done), 16'd0);
    checkOutput("halt_f_stall", 16'(f_stall), 16'd1);
    applyStimulus(1'b1, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0200, 16'h0000);
    waitDone("halt_d_done", 1'b1, 16'h0000, 16'h0000, cyc, wrc);
    checkOutput("halt_d_latency", 16'(cyc), 16'(LAT + 1));
    checkOutput("halt_d_rdata", d_rdata, 16'h5A5A);
    checkOutput("halt_f_stall_after", 16'(f_stall), 16'd1);
    applyStimulus(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
    checkOutput("unhalt_busy", 16'(busy), 16'd1);
    checkOutput("unhalt_mem_addr", mem_addr, 16'h0010);
    checkOutput("unhalt_mem_wr", 16'(mem_wr), 16'd0);
    waitDone("unhalt_f_done", 1'b0, 16'h0000, 16'h0000, cyc, wrc);
    checkOutput("unhalt_f_rest", 16'(cyc), 16'(LAT));
    applyStimulus(1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();

    // Reset during FETCH aborts the access. No done pulse follows, and
    // f_rdata is cleared.
    applyStimulus(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
    step();
    checkOutput("abort_busy_before", 16'(busy), 16'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort_busy_now", 16'(busy), 16'd0);
    checkOutput("abort_mem_en_now", 16'(mem_en), 16'd0);
    applyStimulus(1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
    rst = 1'b0;
    any_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      any_done = any_done | f_done;
    end
    checkOutput("abort_no_f_done", 16'(any_done), 16'd0);
    checkOutput("abort_f_rdata", f_rdata, 16'h0000);

    // Reload f_rdata with 0xABCD before the alignment case
    applyStimulus(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000);
    waitDone("reload_f_done", 1'b0, 16'h0000, 16'h0000, cyc, wrc);
    applyStimulus(1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();

    // Odd fetch address 0x0011
    applyStimulus(1'b0, 1'b1, 16'h0011, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
`ifdef ARB_ALIGN_CHK_EN
    checkOutput("align_err", 16'(err), 16'd1);
    checkOutput("align_f_done", 16'(f_done), 16'd1);
    checkOutput("align_mem_en", 16'(mem_en), 16'd0);
    checkOutput("align_busy", 16'(busy), 16'd0);
    checkOutput("align_f_rdata", f_rdata, 16'hABCD);
    checkOutput("align_mem_addr", mem_addr, 16'h0010);
    applyStimulus(1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
    checkOutput("align_err_clear", 16'(err), 16'd0);
    checkOutput("align_done_clear", 16'(f_done), 16'd0);
`else
    checkOutput("odd_mem_en", 16'(mem_en), 16'd1);
    checkOutput("odd_mem_addr", mem_addr, 16'h0011);
    checkOutput("odd_err", 16'(err), 16'd0);
    waitDone("odd_f_done", 1'b0, 16'h0000, 16'h0000, cyc, wrc);
    checkOutput("odd_f_rest", 16'(cyc), 16'(LAT));
    checkOutput("odd_f_rdata", f_rdata, 16'h1234);
    checkOutput("odd_err_done", 16'(err), 16'd0);
    applyStimulus(1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
